// File: rtl/cbm_sector_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : cbm_sector_parser_if
// Description : Bundles the byte-stream inputs and the parsed-block outputs
//               of cbm_sector_parser.
//               master : upstream side. Drives enable, sync_active, byte_in,
//                        byte_valid and byte_error. Receives the results.
//               slave  : parser side. Receives the byte stream. Drives the
//                        header fields, the data stream and the status pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface cbm_sector_parser_if;
    logic        enable;
    logic        sync_active;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_error;

    logic        hdr_valid;
    logic        hdr_ok;
    logic [7:0]  hdr_track;
    logic [7:0]  hdr_sector;
    logic [15:0] hdr_id;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [7:0]  data_index;
    logic        sector_done;
    logic        data_ok;
    logic        block_abort;
    logic        busy;

    modport master (
        output enable, sync_active, byte_in, byte_valid, byte_error,
        input  hdr_valid, hdr_ok, hdr_track, hdr_sector, hdr_id,
               data_out, data_out_valid, data_index,
               sector_done, data_ok, block_abort, busy
    );

    modport slave (
        input  enable, sync_active, byte_in, byte_valid, byte_error,
        output hdr_valid, hdr_ok, hdr_track, hdr_sector, hdr_id,
               data_out, data_out_valid, data_index,
               sector_done, data_ok, block_abort, busy
    );
endinterface
`default_nettype wire

// File: rtl/cbm_sector_parser.sv
`default_nettype none
// ============================================================================
// Module      : cbm_sector_parser
// Description : Commodore sector framer. It takes bytes from the GCR decoder
//               and the level from the sync detector, and it recognises
//               header blocks (HDR_ID) and data blocks (DATA_ID). It checks
//               the XOR checksum of each block and reports the header fields,
//               the indexed sector data and per-block status.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               bus (slave)       - enable, sync_active, byte_in/valid/error
//                                   in; hdr_*, data_*, sector_done, data_ok,
//                                   block_abort, busy out
// Revision    : 1.0 - initial release
// ============================================================================
module cbm_sector_parser #(
    parameter int         BLOCK_LEN = 256,
    parameter logic [7:0] HDR_ID    = 8'h08,
    parameter logic [7:0] DATA_ID   = 8'h07
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cbm_sector_parser_if.slave  bus
);

    localparam logic [7:0] c_LAST_IDX = 8'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_ID = 3'd1,
        S_HDR     = 3'd2,
        S_DATA    = 3'd3,
        S_DCSUM   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_sync_q;
    logic [7:0]  r_cnt;       // the low 3 bits count header bytes; all 8 bits count data bytes
    logic [7:0]  r_xor;
    logic        r_err;
    logic [7:0]  r_csum_rx;
    logic [7:0]  r_sector_tmp;
    logic [7:0]  r_track_tmp;
    logic [7:0]  r_id2_tmp;

    logic        r_hdr_valid;
    logic        r_hdr_ok;
    logic [7:0]  r_hdr_track;
    logic [7:0]  r_hdr_sector;
    logic [15:0] r_hdr_id;
    logic [7:0]  r_data_out;
    logic        r_data_out_valid;
    logic [7:0]  r_data_index;
    logic        r_sector_done;
    logic        r_data_ok;
    logic        r_block_abort;

    logic        w_fall;
    logic        w_in_block;
    logic        w_err_any;
    logic [7:0]  w_xor_next;

    assign w_fall     = r_sync_q & ~bus.sync_active;
    assign w_in_block = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_DCSUM);
    assign w_err_any  = r_err | bus.byte_error;
    assign w_xor_next = r_xor ^ bus.byte_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_sync_q         <= 1'b0;
            r_cnt            <= 8'd0;
            r_xor            <= 8'd0;
            r_err            <= 1'b0;
            r_csum_rx        <= 8'd0;
            r_sector_tmp     <= 8'd0;
            r_track_tmp      <= 8'd0;
            r_id2_tmp        <= 8'd0;
            r_hdr_valid      <= 1'b0;
            r_hdr_ok         <= 1'b0;
            r_hdr_track      <= 8'd0;
            r_hdr_sector     <= 8'd0;
            r_hdr_id         <= 16'd0;
            r_data_out       <= 8'd0;
            r_data_out_valid <= 1'b0;
            r_data_index     <= 8'd0;
            r_sector_done    <= 1'b0;
            r_data_ok        <= 1'b0;
            r_block_abort    <= 1'b0;
        end else begin
            // Pulses default low. This also drives them to 0 while enable is low.
            r_hdr_valid      <= 1'b0;
            r_data_out_valid <= 1'b0;
            r_sector_done    <= 1'b0;
            r_block_abort    <= 1'b0;

            if (bus.enable) begin
                r_sync_q <= bus.sync_active;

                if (w_fall) begin
                    // A new sync has ended. Any byte in this cycle is sync
                    // residue and is dropped.
                    if (w_in_block) begin
                        r_block_abort <= 1'b1;
                    end
                    r_state <= S_WAIT_ID;
                end else if (bus.sync_active && w_in_block) begin
                    r_block_abort <= 1'b1;
                    r_state       <= S_IDLE;
                end else if (bus.byte_valid) begin
                    case (r_state)
                        S_WAIT_ID: begin
                            // The ID byte is not part of the checksum, but its
                            // decode error still counts toward the block.
                            r_cnt <= 8'd0;
                            r_xor <= 8'd0;
                            r_err <= bus.byte_error;
                            if (bus.byte_in == HDR_ID) begin
                                r_state <= S_HDR;
                            end else if (bus.byte_in == DATA_ID) begin
                                r_state <= S_DATA;
                            end else begin
                                r_block_abort <= 1'b1;
                                r_state       <= S_IDLE;
                            end
                        end

                        S_HDR: begin
                            r_err <= w_err_any;
                            r_cnt <= r_cnt + 8'd1;
                            case (r_cnt[2:0])
                                3'd0: r_csum_rx <= bus.byte_in;
                                3'd1: begin
                                    r_sector_tmp <= bus.byte_in;
                                    r_xor        <= w_xor_next;
                                end
                                3'd2: begin
                                    r_track_tmp <= bus.byte_in;
                                    r_xor       <= w_xor_next;
                                end
                                3'd3: begin
                                    r_id2_tmp <= bus.byte_in;
                                    r_xor     <= w_xor_next;
                                end
                                default: begin
                                    // The fifth byte is id1. The block is complete.
                                    r_hdr_valid  <= 1'b1;
                                    r_hdr_ok     <= (r_csum_rx == w_xor_next) && !w_err_any;
                                    r_hdr_track  <= r_track_tmp;
                                    r_hdr_sector <= r_sector_tmp;
                                    r_hdr_id     <= {bus.byte_in, r_id2_tmp};
                                    r_state      <= S_IDLE;
                                end
                            endcase
                        end

                        S_DATA: begin
                            r_data_out       <= bus.byte_in;
                            r_data_index     <= r_cnt;
                            r_data_out_valid <= 1'b1;
                            r_xor            <= w_xor_next;
                            r_err            <= w_err_any;
                            r_cnt            <= r_cnt + 8'd1;
                            if (r_cnt == c_LAST_IDX) begin
                                r_state <= S_DCSUM;
                            end
                        end

                        S_DCSUM: begin
                            r_sector_done <= 1'b1;
                            r_data_ok     <= (bus.byte_in == r_xor) && !w_err_any;
                            r_state       <= S_IDLE;
                        end

                        default: begin
                            // Bytes in IDLE, such as 0x0F gap padding, are ignored.
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.hdr_valid      = r_hdr_valid;
    assign bus.hdr_ok         = r_hdr_ok;
    assign bus.hdr_track      = r_hdr_track;
    assign bus.hdr_sector     = r_hdr_sector;
    assign bus.hdr_id         = r_hdr_id;
    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_data_out_valid;
    assign bus.data_index     = r_data_index;
    assign bus.sector_done    = r_sector_done;
    assign bus.data_ok        = r_data_ok;
    assign bus.block_abort    = r_block_abort;
    assign bus.busy           = w_in_block;

endmodule
`default_nettype wire

// File: tb/tb_cbm_sector_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbm_sector_parser
// Description : Directed self-checking bench for cbm_sector_parser. It covers
//               header and data blocks with good and bad checksums, byte
//               errors, sync aborts, unknown IDs, a sync edge that coincides
//               with a byte, reset in the middle of a block, and enable hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbm_sector_parser;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cnt_hdr;
    int   cnt_dv;
    int   cnt_sd;

    cbm_sector_parser_if bus ();

    cbm_sector_parser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.hdr_valid)      cnt_hdr++;
        if (bus.data_out_valid) cnt_dv++;
        if (bus.sector_done)    cnt_sd++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic e = 1'b0);
        bus.byte_in    = b;
        bus.byte_error = e;
        bus.byte_valid = 1'b1;
        tick();
    endtask

    task automatic stop();
        bus.byte_valid = 1'b0;
        bus.byte_error = 1'b0;
    endtask

    task automatic send_sync();
        stop();
        bus.sync_active = 1'b1;
        tick();
        bus.sync_active = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pulses"}, {28'd0, bus.hdr_valid, bus.data_out_valid, bus.sector_done, bus.block_abort}, 32'd0);
        chk({tag, "_flags"},  {29'd0, bus.hdr_ok, bus.data_ok, bus.busy}, 32'd0);
        chk({tag, "_hdr"},    {bus.hdr_track, bus.hdr_sector, bus.hdr_id}, 32'd0);
        chk({tag, "_data"},   {16'd0, bus.data_out, bus.data_index}, 32'd0);
    endtask

    // Track 0x12, sector 0, id2 0x42, id1 0x41, with the given checksum byte.
    // Assumes the parser is already in WAIT_ID.
    task automatic do_header(input string tag, input logic [7:0] csum, input logic want_ok);
        int h0;
        h0 = cnt_hdr;
        send(8'h08);
        chk({tag, "_busy_id"}, 32'(bus.busy), 32'd1);
        send(csum);
        send(8'h00);
        send(8'h12);
        send(8'h42);
        chk({tag, "_no_early"}, 32'(bus.hdr_valid), 32'd0);
        send(8'h41);
        stop();
        chk({tag, "_hv"},     32'(bus.hdr_valid), 32'd1);
        chk({tag, "_ok"},     32'(bus.hdr_ok), 32'(want_ok));
        chk({tag, "_fields"}, {bus.hdr_track, bus.hdr_sector, bus.hdr_id}, 32'h1200_4142);
        tick();
        chk({tag, "_hv_pulse"}, {30'd0, bus.hdr_valid, bus.busy}, 32'd0);
        chk({tag, "_hv_count"}, 32'(cnt_hdr - h0), 32'd1);
    endtask

    // Data bytes 0x00..0xFF. The XOR of these bytes is 0x00. err_idx selects
    // the byte that carries byte_error; a value of 256 or more means no error.
    task automatic do_data(input string tag, input logic [7:0] csum, input int err_idx, input logic want_ok);
        int d0;
        int s0;
        int bad;
        logic [7:0] b;
        d0  = cnt_dv;
        s0  = cnt_sd;
        bad = 0;
        send_sync();
        send(8'h07);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send(b, (i == err_idx));
            if ({bus.data_out_valid, bus.data_out, bus.data_index} !== {1'b1, b, b}) bad++;
        end
        chk({tag, "_stream"}, 32'(bad), 32'd0);
        chk({tag, "_no_early_sd"}, 32'(bus.sector_done), 32'd0);
        send(csum);
        stop();
        chk({tag, "_dv_after"}, 32'(bus.data_out_valid), 32'd0);
        chk({tag, "_sd"},       32'(bus.sector_done), 32'd1);
        chk({tag, "_ok"},       32'(bus.data_ok), 32'(want_ok));
        tick();
        chk({tag, "_sd_pulse"}, {30'd0, bus.sector_done, bus.busy}, 32'd0);
        chk({tag, "_dv_count"}, 32'(cnt_dv - d0), 32'd256);
        chk({tag, "_sd_count"}, 32'(cnt_sd - s0), 32'd1);
    endtask

    initial begin
        int h0;
        int d0;
        int s0;
        n_vec = 0;
        n_err = 0;
        cnt_hdr = 0;
        cnt_dv  = 0;
        cnt_sd  = 0;
        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.sync_active = 1'b0;
        bus.byte_in     = 8'h00;
        bus.byte_valid  = 1'b0;
        bus.byte_error  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("rst");

        // Padding in IDLE is ignored.
        send(8'h0F);
        send(8'h08);
        stop();
        chk("idle_ignore", {30'd0, bus.busy, bus.block_abort}, 32'd0);

        // Header with a good checksum, then with a bad one.
        send_sync();
        do_header("hdr_good", 8'h11, 1'b1);
        send(8'h0F);
        send(8'h0F);
        stop();
        send_sync();
        do_header("hdr_bad", 8'h10, 1'b0);

        // Data blocks: good, bad checksum, and byte_error on byte 100.
        do_data("data_good", 8'h00, 1000, 1'b1);
        do_data("data_badcs", 8'h01, 1000, 1'b0);
        do_data("data_err", 8'h00, 100, 1'b0);

        // sync_active rises again after data byte 50: block aborts.
        s0 = cnt_sd;
        send_sync();
        send(8'h07);
        for (int i = 0; i <= 50; i++) send(8'(i));
        stop();
        bus.sync_active = 1'b1;
        tick();
        chk("abort_pulse", 32'(bus.block_abort), 32'd1);
        tick();
        chk("abort_width", {30'd0, bus.block_abort, bus.busy}, 32'd0);
        bus.sync_active = 1'b0;
        tick();
        chk("abort_fall_idle", 32'(bus.block_abort), 32'd0);
        chk("abort_no_sd", 32'(cnt_sd - s0), 32'd0);
        do_header("hdr_after_abort", 8'h11, 1'b1);

        // A falling sync edge with a byte in the same cycle. The byte is
        // discarded and the parser waits for the ID.
        bus.sync_active = 1'b1;
        tick();
        bus.sync_active = 1'b0;
        send(8'h08);
        stop();
        chk("simul_busy", 32'(bus.busy), 32'd0);
        do_header("hdr_after_simul", 8'h11, 1'b1);

        // Unknown ID byte.
        h0 = cnt_hdr;
        send_sync();
        send(8'h55);
        chk("unk_abort", {30'd0, bus.block_abort, bus.busy}, 32'd2);
        send(8'h08);
        chk("unk_abort_width", {30'd0, bus.block_abort, bus.busy}, 32'd0);
        send(8'h11);
        send(8'h00);
        send(8'h12);
        send(8'h42);
        send(8'h41);
        stop();
        tick();
        chk("unk_ignored", {31'd0, bus.busy}, 32'd0);
        chk("unk_no_hdr", 32'(cnt_hdr - h0), 32'd0);

        // enable held low for 10 cycles in the middle of a header.
        h0 = cnt_hdr;
        send_sync();
        send(8'h08);
        send(8'h11);
        send(8'h00);
        stop();
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.byte_valid  = (i == 2);
            bus.byte_in     = 8'hFF;
            bus.sync_active = (i >= 4 && i < 6);
            tick();
        end
        stop();
        chk("en_hold_busy", 32'(bus.busy), 32'd1);
        chk("en_hold_quiet", {30'd0, bus.block_abort, bus.hdr_valid}, 32'd0);
        chk("en_hold_no_hdr", 32'(cnt_hdr - h0), 32'd0);
        bus.enable = 1'b1;
        send(8'h12);
        send(8'h42);
        send(8'h41);
        stop();
        chk("en_resume_hv", {30'd0, bus.hdr_valid, bus.hdr_ok}, 32'd3);
        chk("en_resume_fields", {bus.hdr_track, bus.hdr_sector, bus.hdr_id}, 32'h1200_4142);
        tick();

        // Reset in the middle of a data block.
        s0 = cnt_sd;
        send_sync();
        send(8'h07);
        for (int i = 0; i < 10; i++) send(8'(i + 16));
        stop();
        chk("pre_rst_data", {16'd0, bus.data_out, bus.data_index}, 32'h0000_1909);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("mid_rst");
        d0 = cnt_dv;
        send(8'hAA);
        send(8'hBB);
        stop();
        tick();
        chk("mid_rst_no_dv", 32'(cnt_dv - d0), 32'd0);
        chk("mid_rst_no_sd", 32'(cnt_sd - s0), 32'd0);
        chk("mid_rst_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
